// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory/port bus arbiter: FSM states, address map
// regions and the write-permission rule.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REGION_ROM     = 2'd0,
    REGION_RAM     = 2'd1,
    REGION_OUT_PRT = 2'd2,
    REGION_IN_PRT  = 2'd3
  } region_t;

  localparam logic [7:0] ROM_LAST      = 8'h7F;
  localparam logic [7:0] RAM_BASE      = 8'h80;
  localparam logic [7:0] OUT_PORT_BASE = 8'hE0;
  localparam logic [7:0] IN_PORT_BASE  = 8'hF0;

  function automatic region_t addr_region(input logic [7:0] addr);
    region_t r;
    if (addr <= ROM_LAST)
      r = REGION_ROM;
    else if (addr >= IN_PORT_BASE)
      r = REGION_IN_PRT;
    else if (addr >= OUT_PORT_BASE)
      r = REGION_OUT_PRT;
    else if (addr >= RAM_BASE)
      r = REGION_RAM;
    else
      r = REGION_ROM;
    return r;
  endfunction

  // ROM and input ports are read-only; everything else accepts writes.
  function automatic logic write_legal(input logic [7:0] addr);
    region_t r;
    r = addr_region(addr);
    return (r == REGION_RAM) || (r == REGION_OUT_PRT);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester that did not win last
// time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1)
      grant_id = ~last_grant;
    else
      grant_id = req1 & ~req0;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between CPU (requester 0) and DMA
// (requester 1), running each transaction as a fixed 4-cycle sequence.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   cur_we;
  logic   cur_legal;

  logic              grant_valid;
  logic              grant_id;
  logic              sel_we;
  logic              sel_legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = grant_id ? we1    : we0;
    sel_addr  = grant_id ? addr1  : addr0;
    sel_wdata = grant_id ? wdata1 : wdata0;
    sel_legal = write_legal(sel_addr);
  end

  // mem_address doubles as the latched transaction address, so it is simply
  // left holding its value through HOLD and RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      cur_legal   <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_id      <= grant_id;
            cur_we      <= sel_we;
            cur_legal   <= sel_legal;
            last_grant  <= grant_id;
            mem_address <= sel_addr;
            mem_data_in <= sel_wdata;
            mem_write   <= sel_we & sel_legal;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!cur_we) begin
            if (cur_id)
              rdata1 <= mem_data_out;
            else
              rdata0 <= mem_data_out;
          end
          if (cur_id) begin
            ack1 <= 1'b1;
            err1 <= cur_we & ~cur_legal;
          end else begin
            ack0 <= 1'b1;
            err0 <= cur_we & ~cur_legal;
          end
          state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
